// File: rtl/tb_system_ctrl_pkg.sv
// Shared types and constants for the behavioural system shell:
// boot FSM states, boot-mode encodings and program exit codes.
package tb_system_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLL_LOCK = 3'd1,
        LOAD     = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic BOOT_JTAG  = 1'b0;
    localparam logic BOOT_FLASH = 1'b1;

    localparam logic [31:0] EXIT_OK          = 32'd0;
    localparam logic [31:0] EXIT_ILLEGAL_CFG = 32'd1;

endpackage

// File: rtl/tb_system_ctrl_if.sv
// Boot configuration and exit reporting bundle between the bench (master)
// and the system shell (slave).
interface tb_system_ctrl_if;
    logic        boot_select_i;
    logic        execute_from_flash_i;
    logic        bypass_fll_i;
    logic        exit_valid_o;
    logic [31:0] exit_value_o;

    modport master (
        output boot_select_i, execute_from_flash_i, bypass_fll_i,
        input  exit_valid_o, exit_value_o
    );

    modport slave (
        input  boot_select_i, execute_from_flash_i, bypass_fll_i,
        output exit_valid_o, exit_value_o
    );
endinterface

// File: rtl/tb_system_ctrl_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second rising edge after the external reset falls.
module tb_system_ctrl_rst_sync (
    input  logic clk,
    input  logic rst,
    output logic core_rst
);
    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], 1'b0};
        end
    end

    assign core_rst = sync_reg[1];
endmodule

// File: rtl/tb_system_ctrl.sv
// Boot sequencer stand-in: FLL lock wait, firmware load, program run and
// sticky exit-code reporting.
module tb_system_ctrl
    import tb_system_ctrl_pkg::*;
#(
    parameter int CLK_FREQ          = 100000,
    parameter int JTAG_LOAD_CYCLES  = 64,
    parameter int FLASH_LOAD_CYCLES = 128,
    parameter int RUN_STEPS         = 64
) (
    input  logic              ref_clk_i,
    input  logic              rst_i,
    tb_system_ctrl_if.slave   sys
);
    localparam logic [31:0] FLL_LEN     = 32'(CLK_FREQ / 1000);
    localparam logic [31:0] JTAG_LEN    = 32'(JTAG_LOAD_CYCLES);
    localparam logic [31:0] FLASH_LEN   = 32'(FLASH_LOAD_CYCLES);
    localparam logic [31:0] RUN_LEN     = 32'(RUN_STEPS);
    localparam logic [31:0] RUN_LEN_XIP = 32'(2 * RUN_STEPS);
    localparam logic [31:0] STEP_SUM    = 32'(RUN_STEPS * (RUN_STEPS - 1) / 2);

    logic        core_rst;
    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] acc_reg, acc_next;
    logic        boot_reg, boot_next;
    logic        xip_reg, xip_next;
    logic        bypass_reg, bypass_next;
    logic        exit_valid_reg, exit_valid_next;
    logic [31:0] exit_value_reg, exit_value_next;
    logic [31:0] step;
    logic        step_en;
    logic [31:0] run_len;
    logic [31:0] load_len;

    tb_system_ctrl_rst_sync u_rst_sync (
        .clk      (ref_clk_i),
        .rst      (rst_i),
        .core_rst (core_rst)
    );

    // Executing in place inserts a wait state: a step lands on every odd cycle.
    assign step     = xip_reg ? {1'b0, cnt_reg[31:1]} : cnt_reg;
    assign step_en  = !xip_reg || cnt_reg[0];
    assign run_len  = xip_reg ? RUN_LEN_XIP : RUN_LEN;
    assign load_len = (boot_reg == BOOT_FLASH) ? FLASH_LEN : JTAG_LEN;

    always_ff @(posedge ref_clk_i or posedge core_rst) begin
        if (core_rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            acc_reg        <= '0;
            boot_reg       <= BOOT_JTAG;
            xip_reg        <= 1'b0;
            bypass_reg     <= 1'b0;
            exit_valid_reg <= 1'b0;
            exit_value_reg <= EXIT_OK;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            acc_reg        <= acc_next;
            boot_reg       <= boot_next;
            xip_reg        <= xip_next;
            bypass_reg     <= bypass_next;
            exit_valid_reg <= exit_valid_next;
            exit_value_reg <= exit_value_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        acc_next        = acc_reg;
        boot_next       = boot_reg;
        xip_next        = xip_reg;
        bypass_next     = bypass_reg;
        exit_valid_next = exit_valid_reg;
        exit_value_next = exit_value_reg;

        case (state_reg)
            IDLE: begin
                // Live inputs steer the first decision while they are captured.
                boot_next   = sys.boot_select_i;
                xip_next    = sys.execute_from_flash_i;
                bypass_next = sys.bypass_fll_i;
                cnt_next    = '0;
                if (sys.execute_from_flash_i && (sys.boot_select_i == BOOT_JTAG)) begin
                    state_next      = DONE;
                    exit_valid_next = 1'b1;
                    exit_value_next = EXIT_ILLEGAL_CFG;
                end else if (!sys.bypass_fll_i) begin
                    state_next = FLL_LOCK;
                end else if (sys.execute_from_flash_i) begin
                    state_next = RUN;
                end else begin
                    state_next = LOAD;
                end
            end
            FLL_LOCK: begin
                if (cnt_reg == FLL_LEN - 32'd1) begin
                    cnt_next   = '0;
                    state_next = ((boot_reg == BOOT_FLASH) && xip_reg) ? RUN : LOAD;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            LOAD: begin
                if (cnt_reg == load_len - 32'd1) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            RUN: begin
                if (step_en) begin
                    acc_next = acc_reg + step;
                end
                if (cnt_reg == run_len - 32'd1) begin
                    cnt_next        = '0;
                    state_next      = DONE;
                    exit_valid_next = 1'b1;
                    exit_value_next = acc_next - STEP_SUM;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sys.exit_valid_o = exit_valid_reg;
    assign sys.exit_value_o = exit_value_reg;
endmodule

// File: tb/tb_tb_system_ctrl.sv
// Scoreboard bench for the boot sequencer: stimulus queues expected exit
// edge/value per boot; a negedge monitor checks each exit_valid rise.
module tb_tb_system_ctrl;
    import tb_system_ctrl_pkg::*;

    typedef struct {
        int          edges;
        logic [31:0] value;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    tb_system_ctrl_if sys ();

    tb_system_ctrl #(
        .CLK_FREQ          (100000),
        .JTAG_LOAD_CYCLES  (64),
        .FLASH_LOAD_CYCLES (128),
        .RUN_STEPS         (64)
    ) dut (
        .ref_clk_i (clk),
        .rst_i     (rst),
        .sys       (sys)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (sys.exit_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_exit: got rise at edge %0d, required no exit", edge_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("[TB] exit %s edges=%0d value=%0d", mon_e.name, edge_cnt, sys.exit_value_o);
                    check({mon_e.name, "_edges"}, 32'(edge_cnt), 32'(mon_e.edges));
                    check({mon_e.name, "_value"}, sys.exit_value_o, mon_e.value);
                end
            end
            prev_valid <= sys.exit_valid_o;
        end
    end

    // Assert reset, check outputs clear at once, then set up the config.
    task automatic apply_reset(input string name, input logic bypass, input logic boot, input logic xip);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({name, "_rst_valid"}, 32'(sys.exit_valid_o), 32'd0);
        check({name, "_rst_value"}, sys.exit_value_o, 32'd0);
        sys.bypass_fll_i         = bypass;
        sys.boot_select_i        = boot;
        sys.execute_from_flash_i = xip;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_exp(input string name, input int edges, input logic [31:0] value);
        exp_t e;
        e.edges = edges;
        e.value = value;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_exit(input string name, input int bound);
        int n = 0;
        while (!sys.exit_valid_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!sys.exit_valid_o) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no exit after %0d cycles, required exit", name, bound);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int hold_bad;
        sys.bypass_fll_i         = 1'b1;
        sys.boot_select_i        = BOOT_JTAG;
        sys.execute_from_flash_i = 1'b0;
        repeat (3) @(negedge clk);

        // jtag boot, fll bypassed
        apply_reset("jtag_bypass", 1'b1, BOOT_JTAG, 1'b0);
        push_exp("jtag_bypass", 131, EXIT_OK);
        release_rst();
        wait_exit("jtag_bypass", 400);

        // flash boot with fll lock
        apply_reset("flash_fll", 1'b0, BOOT_FLASH, 1'b0);
        push_exp("flash_fll", 295, EXIT_OK);
        release_rst();
        wait_exit("flash_fll", 400);

        // execute in place
        apply_reset("xip", 1'b1, BOOT_FLASH, 1'b1);
        push_exp("xip", 131, EXIT_OK);
        release_rst();
        wait_exit("xip", 400);

        // illegal: xip with jtag boot
        apply_reset("illegal", 1'b1, BOOT_JTAG, 1'b1);
        push_exp("illegal", 3, EXIT_ILLEGAL_CFG);
        release_rst();
        wait_exit("illegal", 400);

        // abort mid-run, then rerun with fll lock
        apply_reset("abort", 1'b1, BOOT_JTAG, 1'b0);
        release_rst();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(sys.exit_valid_o), 32'd0);
        check("abort_value", sys.exit_value_o, 32'd0);
        sys.bypass_fll_i = 1'b0;
        repeat (2) @(negedge clk);
        push_exp("rerun", 231, EXIT_OK);
        release_rst();
        wait_exit("rerun", 400);

        // config toggled during load must be ignored
        apply_reset("toggle", 1'b0, BOOT_FLASH, 1'b0);
        push_exp("toggle", 295, EXIT_OK);
        release_rst();
        repeat (150) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sys.bypass_fll_i         = ~sys.bypass_fll_i;
            sys.boot_select_i        = ~sys.boot_select_i;
            sys.execute_from_flash_i = ~sys.execute_from_flash_i;
            @(negedge clk);
        end
        wait_exit("toggle", 400);

        hold_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 300) sys.boot_select_i = ~sys.boot_select_i;
            if (sys.exit_valid_o !== 1'b1 || sys.exit_value_o !== EXIT_OK) hold_bad++;
            @(negedge clk);
        end
        check("hold_done", 32'(hold_bad), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("done_rst_valid", 32'(sys.exit_valid_o), 32'd0);
        repeat (2) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tb_system_ctrl.md
Name: tb_system_ctrl

Overview:
Self-contained behavioural stand-in for the simulation system shell that the top-level testbench drives.
- Models boot sequencing: FLL lock wait, firmware load (JTAG or SPI flash), execute-in-place option, firmware run.
- Reports the program exit code on exit_valid_o/exit_value_o, where the testbench prints TEST SUCCEEDED/FAILED.
- Single clock domain; no external memories.

Parameters:
CLK_FREQ, 100000, reference clock frequency in kHz; FLL lock time = CLK_FREQ/1000 cycles (1 us).
JTAG_LOAD_CYCLES, 64, cycles to load firmware over JTAG.
FLASH_LOAD_CYCLES, 128, cycles to copy firmware from flash to SRAM.
RUN_STEPS, 64, number of program steps executed (must be >= 1).

Ports:
ref_clk_i  in  1  reference/system clock, rising edge.
rst_i  in  1  asynchronous active-high reset.
boot_select_i  in  1  0 = JTAG boot, 1 = flash boot.
execute_from_flash_i  in  1  1 = execute in place from flash (flash boot only).
bypass_fll_i  in  1  1 = skip FLL lock wait.
exit_valid_o  out  1  program finished; sticky until reset.
exit_value_o  out  32  program return code; 0 = success.

Behaviour:
- Reset and outputs
  - rst_i asserts asynchronously.
  - Internal reset release goes through a 2-flop synchronizer, so the core sees reset for 2 edges after rst_i falls.
  - Reset values: exit_valid_o=0, exit_value_o=0, FSM=IDLE, counters=0, acc=0.
- Config sampling
  - boot_select_i, execute_from_flash_i and bypass_fll_i are registered in IDLE, in the first core cycle after reset release.
  - Later input changes are ignored until the next reset.
- FSM states: IDLE, FLL_LOCK, LOAD, RUN, DONE. Each timed state lasts exactly its count, then advances.
  - IDLE (1 cycle):
    - exec_from_flash=1 with boot=0 is illegal → DONE with code 1.
    - Otherwise → FLL_LOCK, or straight to the load/run decision if bypass=1.
  - FLL_LOCK (CLK_FREQ/1000 cycles):
    - flash boot with exec_from_flash=1 → RUN.
    - otherwise → LOAD.
  - LOAD: JTAG_LOAD_CYCLES (boot=0) or FLASH_LOAD_CYCLES (boot=1), then → RUN.
  - RUN:
    - Step k = 0..RUN_STEPS-1 performs acc <= acc + k (32-bit, wrap mod 2^32).
    - One step per cycle; one step per 2 cycles when executing from flash (wait state).
    - After the last step → DONE with code = acc − RUN_STEPS·(RUN_STEPS−1)/2 (mod 2^32), i.e. 0 when correct.
  - DONE:
    - exit_valid_o=1 and exit_value_o=code, both registered and stable until reset.
    - FSM stays in DONE.
- Latency: exit_valid_o rises at core cycle 1 + L_fll + L_load + L_run, with core cycle 0 being the IDLE cycle.
  - L_fll = 0 if bypassed.
  - L_load = 0 if executing in place.
  - L_run = RUN_STEPS, or 2·RUN_STEPS when executing in place.
  - Illegal config: exit_valid_o rises at core cycle 1.
- rst_i asserted in any state aborts immediately (outputs clear in the same instant); the sequence restarts from IDLE with freshly sampled config.

Decomposition:
- Package tb_system_ctrl_pkg:
  - state enum (IDLE, FLL_LOCK, LOAD, RUN, DONE)
  - boot-mode constants (BOOT_JTAG=0, BOOT_FLASH=1)
  - exit codes (EXIT_OK=0, EXIT_ILLEGAL_CFG=1)
- One sub-module rst_sync (2-flop async-assert/sync-deassert) is natural. FSM, counters and accumulator stay in the top module.

Test Plan:
1. Defaults, bypass=1, boot=0, exec=0 → exit_valid_o rises 2+1+64+64 = 131 edges after rst_i falls; exit_value_o=0.
2. bypass=0, boot=1, exec=0 → rise at 2+1+100+128+64 = 295 edges; value 0.
3. bypass=1, boot=1, exec=1 → rise at 2+1+0+128 = 131 edges; value 0.
4. bypass=1, boot=0, exec=1 (illegal) → rise at 3 edges; exit_value_o=1.
5. rst_i pulsed high during RUN of scenario 1 → outputs 0 at once; then rerun with bypass=0 → rise at 2+1+100+64+64 = 231 edges after the second release.
6. Toggle all config inputs during LOAD of scenario 2 → timing (295) and value (0) unchanged; outputs hold in DONE for 1000 further cycles.
